avalon_master_traffic_gen: RTL and testbench

- Parametrised Avalon-MM master test engine; successor to the single-access master example.
- A start strobe launches a multi-word burst-free sequence in one of three modes: write, read, or write-then-readback-verify.
- Generalised in address/data width and transfer length, with pipelined reads up to MAX_PENDING outstanding and a pattern checker.
- Sits between a test controller (bench or FPGA-side control logic) and any Avalon-MM slave, e.g. the SDRAM/PCIe bridge.

---
 rtl/avalon_master_traffic_gen_if.sv | 25 ++
 rtl/avalon_master_traffic_gen.sv | 205 ++++++++++++++++++++
 tb/tb_avalon_master_traffic_gen.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/avalon_master_traffic_gen_if.sv
// Avalon-MM master/slave signal bundle for the traffic generator.
// Byteenable travels with the request so that any slave can be attached unchanged.
interface avalon_master_traffic_gen_if #(
    parameter int ADDR_W = 26,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   avm_address;
    logic                avm_read;
    logic                avm_write;
    logic [DATA_W-1:0]   avm_writedata;
    logic [DATA_W/8-1:0] avm_byteenable;
    logic                avm_waitrequest;
    logic [DATA_W-1:0]   avm_readdata;
    logic                avm_readdatavalid;

    modport master (
        output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
        input  avm_waitrequest, avm_readdata, avm_readdatavalid
    );

    modport slave (
        input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
        output avm_waitrequest, avm_readdata, avm_readdatavalid
    );
endinterface

// File: rtl/avalon_master_traffic_gen.sv
// Avalon-MM traffic generator: writes an incrementing pattern, reads it back with
// up to MAX_PENDING outstanding reads, and counts read-data mismatches.
module avalon_master_traffic_gen #(
    parameter int ADDR_W      = 26,
    parameter int DATA_W      = 32,
    parameter int LEN_W       = 16,
    parameter int MAX_PENDING = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                n_action,
    input  logic [1:0]          mode,
    input  logic [ADDR_W-1:0]   base_address,
    input  logic [LEN_W-1:0]    word_count,
    input  logic [DATA_W-1:0]   seed,
    avalon_master_traffic_gen_if.master avm,
    output logic                busy,
    output logic                done,
    output logic [LEN_W-1:0]    error_count,
    output logic [ADDR_W-1:0]   first_err_addr,
    output logic                pass
);
    localparam int PEND_W = $clog2(MAX_PENDING + 1);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(DATA_W / 8);
    localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(MAX_PENDING);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [1:0]          r_mode;
    logic [ADDR_W-1:0]   r_base;
    logic [LEN_W-1:0]    r_count;
    logic [LEN_W-1:0]    r_idx;
    logic [LEN_W-1:0]    r_rx_idx;
    logic [PEND_W-1:0]   r_pending;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_expect;
    logic [ADDR_W-1:0]   r_rx_addr;
    logic                r_read;
    logic                r_write;
    logic                r_busy;
    logic                r_done;
    logic                r_pass;
    logic [LEN_W-1:0]    r_err_cnt;
    logic [ADDR_W-1:0]   r_first_err;

    logic                w_wr_acc;
    logic                w_rd_acc;
    logic                w_rdv;
    logic                w_mismatch;
    logic                w_last_wr;
    logic [LEN_W-1:0]    w_issued_next;
    logic [LEN_W-1:0]    w_rx_next;
    logic [PEND_W-1:0]   w_pend_next;
    logic [LEN_W-1:0]    w_err_next;

    assign w_wr_acc      = r_write & ~avm.avm_waitrequest;
    assign w_rd_acc      = r_read & ~avm.avm_waitrequest;
    // Stray read data outside a read phase (e.g. after an abort) must not touch the checker.
    assign w_rdv         = avm.avm_readdatavalid & ((r_state == S_READ) | (r_state == S_DRAIN));
    assign w_mismatch    = w_rdv & (avm.avm_readdata != r_expect);
    assign w_last_wr     = (r_idx == r_count - LEN_W'(1));
    assign w_issued_next = r_idx + LEN_W'(w_rd_acc);
    assign w_rx_next     = r_rx_idx + LEN_W'(w_rdv);
    assign w_pend_next   = r_pending + PEND_W'(w_rd_acc) - PEND_W'(w_rdv);
    assign w_err_next    = (w_mismatch && (r_err_cnt != '1)) ? r_err_cnt + LEN_W'(1) : r_err_cnt;

    // NOTE: every register here is written with <= so that all next-state terms
    // above see the same pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_mode      <= '0;
            r_base      <= '0;
            r_count     <= '0;
            r_idx       <= '0;
            r_rx_idx    <= '0;
            r_pending   <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_expect    <= '0;
            r_rx_addr   <= '0;
            r_read      <= 1'b0;
            r_write     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_cnt   <= '0;
            r_first_err <= '0;
        end else begin
            if (w_rdv) begin
                r_rx_idx  <= w_rx_next;
                r_expect  <= r_expect + DATA_W'(1);
                r_rx_addr <= r_rx_addr + ADDR_STEP;
                r_err_cnt <= w_err_next;
                if (w_mismatch && (r_err_cnt == '0)) begin
                    r_first_err <= r_rx_addr;
                end
            end
            if ((r_state == S_READ) || (r_state == S_DRAIN)) begin
                r_pending <= w_pend_next;
            end

            case (r_state)
                S_IDLE: begin
                    if (!n_action) begin
                        r_mode      <= mode;
                        r_base      <= base_address;
                        r_count     <= word_count;
                        r_idx       <= '0;
                        r_rx_idx    <= '0;
                        r_pending   <= '0;
                        r_addr      <= base_address;
                        r_wdata     <= seed;
                        r_expect    <= seed;
                        r_rx_addr   <= base_address;
                        r_err_cnt   <= '0;
                        r_first_err <= '0;
                        r_pass      <= 1'b0;
                        if (word_count == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_pass  <= (mode != 2'b00);
                        end else if (!mode[0]) begin
                            r_state <= S_WRITE;
                            r_write <= 1'b1;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= S_READ;
                            r_read  <= 1'b1;
                            r_busy  <= 1'b1;
                        end
                    end
                end

                S_WRITE: begin
                    if (w_wr_acc) begin
                        r_idx   <= r_idx + LEN_W'(1);
                        r_addr  <= r_addr + ADDR_STEP;
                        r_wdata <= r_wdata + DATA_W'(1);
                        if (w_last_wr) begin
                            r_write <= 1'b0;
                            if (r_mode == 2'b10) begin
                                r_state <= S_READ;
                                r_idx   <= '0;
                                r_addr  <= r_base;
                                r_read  <= 1'b1;
                            end else begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                            end
                        end
                    end
                end

                S_READ: begin
                    r_idx  <= w_issued_next;
                    r_read <= (w_issued_next < r_count) && (w_pend_next < PEND_MAX);
                    if (w_rd_acc) begin
                        r_addr <= r_addr + ADDR_STEP;
                    end
                    if (w_issued_next == r_count) begin
                        r_state <= S_DRAIN;
                    end
                end

                S_DRAIN: begin
                    if (w_rx_next == r_count) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_pass  <= (w_err_next == '0);
                    end
                end

                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign avm.avm_address    = r_addr;
    assign avm.avm_read       = r_read;
    assign avm.avm_write      = r_write;
    assign avm.avm_writedata  = r_wdata;
    assign avm.avm_byteenable = '1;

    assign busy           = r_busy;
    assign done           = r_done;
    assign error_count    = r_err_cnt;
    assign first_err_addr = r_first_err;
    assign pass           = r_pass;
endmodule

// File: tb/tb_avalon_master_traffic_gen.sv
// Bench for avalon_master_traffic_gen: memory-backed slave with stalls and read latency,
// expected traffic and error results derived from the access pattern rules.
module tb_avalon_master_traffic_gen;
    logic        clock;
    logic        reset;
    logic        n_action;
    logic [1:0]  mode;
    logic [25:0] base_address;
    logic [15:0] word_count;
    logic [31:0] seed;
    logic        busy;
    logic        done;
    logic [15:0] error_count;
    logic [25:0] first_err_addr;
    logic        pass;

    avalon_master_traffic_gen_if #(.ADDR_W(26), .DATA_W(32)) bus ();

    avalon_master_traffic_gen #(
        .ADDR_W(26), .DATA_W(32), .LEN_W(16), .MAX_PENDING(4)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .n_action       (n_action),
        .mode           (mode),
        .base_address   (base_address),
        .word_count     (word_count),
        .seed           (seed),
        .avm            (bus),
        .busy           (busy),
        .done           (done),
        .error_count    (error_count),
        .first_err_addr (first_err_addr),
        .pass           (pass)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- slave model (knobs written only by the initial block) ----------------
    typedef struct { logic [25:0] a; logic [31:0] d; } wr_t;
    typedef struct { int due; logic [25:0] a; } rq_t;

    int          epoch = 0;
    int          lat = 3;
    bit          rand_wait = 0;
    bit          stall_en = 0;
    logic [25:0] stall_addr = '0;
    bit          corrupt_en = 0;
    logic [25:0] corrupt_addr = '0;

    logic [31:0] mem [logic [25:0]];
    wr_t         wlog[$];
    logic [25:0] rlog[$];
    rq_t         rq[$];
    int          cyc = 0;
    int          last_epoch_p = 0;
    int          last_epoch_n = 0;
    int          out_now = 0;
    int          peak = 0;
    int          viol_both = 0;
    int          viol_hold = 0;
    int          stall_used = 0;
    bit          prev_stalled = 0;
    logic [25:0] prev_addr;
    logic [31:0] prev_wd;
    logic        prev_rd, prev_wr;

    always @(posedge clock) begin
        cyc++;
        if (epoch != last_epoch_p) begin
            last_epoch_p = epoch;
            wlog.delete();
            rlog.delete();
            out_now = 0;
            peak = 0;
            viol_both = 0;
            viol_hold = 0;
        end
        if (bus.avm_read && bus.avm_write) viol_both++;
        if (prev_stalled && (bus.avm_address !== prev_addr || bus.avm_writedata !== prev_wd ||
                             bus.avm_read !== prev_rd || bus.avm_write !== prev_wr))
            viol_hold++;
        prev_stalled = (bus.avm_read || bus.avm_write) && bus.avm_waitrequest;
        prev_addr = bus.avm_address;
        prev_wd   = bus.avm_writedata;
        prev_rd   = bus.avm_read;
        prev_wr   = bus.avm_write;
        if (bus.avm_write && !bus.avm_waitrequest) begin
            wlog.push_back('{a: bus.avm_address, d: bus.avm_writedata});
            mem[bus.avm_address] = bus.avm_writedata;
        end
        if (bus.avm_read && !bus.avm_waitrequest) begin
            rlog.push_back(bus.avm_address);
            rq.push_back('{due: cyc + lat, a: bus.avm_address});
            out_now++;
        end
        if (bus.avm_readdatavalid) out_now--;
        if (out_now > peak) peak = out_now;
    end

    always @(negedge clock) begin
        rq_t r;
        logic [31:0] d;
        if (epoch != last_epoch_n) begin
            last_epoch_n = epoch;
            stall_used = 0;
        end
        if (rq.size() > 0 && rq[0].due <= cyc) begin
            r = rq.pop_front();
            d = mem.exists(r.a) ? mem[r.a] : 32'h0;
            if (corrupt_en && r.a == corrupt_addr) d = d ^ 32'h1;
            bus.avm_readdatavalid = 1'b1;
            bus.avm_readdata      = d;
        end else begin
            bus.avm_readdatavalid = 1'b0;
            bus.avm_readdata      = 32'h0;
        end
        if ((bus.avm_read || bus.avm_write) && stall_en && bus.avm_address == stall_addr && stall_used < 3) begin
            bus.avm_waitrequest = 1'b1;
            stall_used++;
        end else begin
            bus.avm_waitrequest = rand_wait ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [logic [25:0]];

    function automatic logic [25:0] addr_of(input logic [25:0] b, input int i);
        return b + 26'(i * 4);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [25:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    task automatic run(input logic [1:0] m, input logic [25:0] b, input logic [15:0] n,
                       input logic [31:0] s, output int cycles, output logic busy_first);
        epoch++;
        @(posedge clock);
        @(negedge clock);
        mode = m; base_address = b; word_count = n; seed = s; n_action = 1'b0;
        @(negedge clock);
        n_action = 1'b1;
        cycles = 1;
        busy_first = busy;
        while (!done && cycles < 2000) begin
            @(negedge clock);
            cycles++;
        end
        check("done_reached", done, 1'b1);
    endtask

    task automatic verify(input string tag, input logic [1:0] m, input logic [25:0] b,
                          input logic [15:0] n, input logic [31:0] s);
        bit          wr = (m == 2'b00) || (m == 2'b10);
        bit          rd = (m != 2'b00);
        int          e = 0;
        logic [25:0] fe = '0;
        logic [25:0] a;
        logic [31:0] d;
        check({tag, "_wr_count"}, wlog.size(), wr ? int'(n) : 0);
        if (wr) begin
            for (int i = 0; i < int'(n); i++) begin
                a = addr_of(b, i);
                d = s + 32'(i);
                ref_mem[a] = d;
                if (i < wlog.size()) begin
                    check({tag, "_wr_addr"}, wlog[i].a, a);
                    check({tag, "_wr_data"}, wlog[i].d, d);
                end
            end
        end
        check({tag, "_rd_count"}, rlog.size(), rd ? int'(n) : 0);
        if (rd) begin
            for (int i = 0; i < int'(n); i++) begin
                a = addr_of(b, i);
                if (i < rlog.size()) check({tag, "_rd_addr"}, rlog[i], a);
                d = ref_rd(a);
                if (corrupt_en && a == corrupt_addr) d = d ^ 32'h1;
                if (d != s + 32'(i)) begin
                    if (e == 0) fe = a;
                    e++;
                end
            end
        end
        check({tag, "_err_count"}, error_count, e);
        check({tag, "_first_err"}, first_err_addr, fe);
        check({tag, "_pass"}, pass, rd && (e == 0));
        check({tag, "_busy_at_done"}, busy, 1'b0);
        check({tag, "_rw_overlap"}, viol_both, 0);
        check({tag, "_hold_stable"}, viol_hold, 0);
        @(negedge clock);
        check({tag, "_done_one_cycle"}, done, 1'b0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int          cycles;
        logic        bf;
        logic [1:0]  m;
        logic [25:0] b;
        logic [15:0] n;
        logic [31:0] s;
        bit          hit;

        reset = 1'b1; n_action = 1'b1; mode = '0; base_address = '0; word_count = '0; seed = '0;
        repeat (3) @(negedge clock);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_pass", pass, 1'b0);
        check("rst_err", error_count, 16'h0);
        check("rst_ferr", first_err_addr, 26'h0);
        check("rst_rw", {bus.avm_read, bus.avm_write}, 2'b00);
        check("rst_addr", bus.avm_address, 26'h0);
        reset = 1'b0;
        @(negedge clock);

        // Plain write burst, no stalls: one word per cycle.
        run(2'b00, 26'h100, 16'd4, 32'hA5A5_0000, cycles, bf);
        check("t1_busy_first", bf, 1'b1);
        check("t1_cycles", cycles, 5);
        verify("t1", 2'b00, 26'h100, 16'd4, 32'hA5A5_0000);

        // Same burst with word 1 stalled for three cycles.
        stall_en = 1; stall_addr = 26'h104;
        run(2'b00, 26'h100, 16'd4, 32'hA5A5_0000, cycles, bf);
        check("t2_stall_cycles", stall_used, 3);
        check("t2_cycles", cycles, 8);
        verify("t2", 2'b00, 26'h100, 16'd4, 32'hA5A5_0000);
        stall_en = 0;

        // Write-then-verify, 3-cycle slave latency: outstanding reads must top out at 4.
        lat = 3;
        s = $urandom;
        run(2'b10, 26'h4000, 16'd16, s, cycles, bf);
        check("t3_peak_pending", peak, 4);
        verify("t3", 2'b10, 26'h4000, 16'd16, s);
        @(negedge clock);
        check("t3_pass_held", pass, 1'b1);

        // Read-only over the same region with word 2 corrupted by the slave.
        corrupt_en = 1; corrupt_addr = 26'h4008;
        run(2'b01, 26'h4000, 16'd16, s, cycles, bf);
        check("t4_err_count", error_count, 16'd1);
        check("t4_first_err", first_err_addr, 26'h4008);
        verify("t4", 2'b01, 26'h4000, 16'd16, s);
        corrupt_en = 0;

        // Zero-length request: completes immediately with no bus traffic.
        run(2'b10, 26'h200, 16'd0, 32'h1234, cycles, bf);
        check("t5_cycles", cycles, 1);
        verify("t5", 2'b10, 26'h200, 16'd0, 32'h1234);

        // Address wrap at the top of the 26-bit space.
        run(2'b00, 26'h3FF_FFF8, 16'd4, 32'h7, cycles, bf);
        if (wlog.size() == 4) begin
            check("t6_wrap_a2", wlog[2].a, 26'h0);
            check("t6_wrap_a3", wlog[3].a, 26'h4);
        end
        verify("t6", 2'b00, 26'h3FF_FFF8, 16'd4, 32'h7);

        // Reset while reads are outstanding.
        epoch++;
        @(posedge clock);
        @(negedge clock);
        mode = 2'b01; base_address = 26'h8000; word_count = 16'd8; seed = 32'h55; n_action = 1'b0;
        @(negedge clock);
        n_action = 1'b1;
        hit = 0;
        for (int k = 0; k < 50 && !hit; k++) begin
            if (out_now >= 2) hit = 1;
            else @(negedge clock);
        end
        check("t7_two_pending", hit, 1'b1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("t7_busy", busy, 1'b0);
        check("t7_rw", {bus.avm_read, bus.avm_write}, 2'b00);
        check("t7_addr", bus.avm_address, 26'h0);
        check("t7_wdata", bus.avm_writedata, 32'h0);
        check("t7_done", done, 1'b0);
        check("t7_err", error_count, 16'h0);
        repeat (10) @(negedge clock);
        check("t7_late_err", error_count, 16'h0);
        check("t7_late_busy", busy, 1'b0);
        check("t7_late_read", bus.avm_read, 1'b0);
        run(2'b10, 26'h9000, 16'd6, 32'hCAFE_0000, cycles, bf);
        verify("t7_rerun", 2'b10, 26'h9000, 16'd6, 32'hCAFE_0000);

        // Randomized runs with random stalls and latency.
        rand_wait = 1;
        for (int r = 0; r < 6; r++) begin
            m = 2'($urandom_range(0, 3));
            b = 26'($urandom);
            n = 16'($urandom_range(1, 12));
            s = $urandom;
            lat = int'($urandom_range(1, 4));
            run(m, b, n, s, cycles, bf);
            verify("rnd", m, b, n, s);
        end
        rand_wait = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
